// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP RISC front end: instruction field layout,
// fetch FSM encoding, reset PC and small field/address helpers.
package kgp_risc_pkg;

    localparam int INSTR_W      = 32;
    localparam int OPCODE_W     = 5;
    localparam int FUNCCODE_W   = 5;
    localparam int REG_W        = 5;
    localparam int IMM_W        = 16;

    localparam int OPCODE_LSB   = 27;
    localparam int RS_LSB       = 22;
    localparam int RT_LSB       = 17;
    localparam int FUNCCODE_LSB = 0;
    localparam int IMM_LSB      = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HOLD = 2'b11
    } fetch_state_e;

    function automatic logic [31:0] sign_ext_imm(input logic [IMM_W-1:0] value);
        return {{(32-IMM_W){value[IMM_W-1]}}, value};
    endfunction

    // Instruction fetches are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational decode of a 32-bit instruction word into its control-unit fields.
module instr_field_split
    import kgp_risc_pkg::*;
(
    input  logic [INSTR_W-1:0]    word,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [FUNCCODE_W-1:0] funccode,
    output logic [REG_W-1:0]      rs,
    output logic [REG_W-1:0]      rt,
    output logic [31:0]           imm
);

    logic unused_bit_s;

    assign opcode       = word[OPCODE_LSB +: OPCODE_W];
    assign funccode     = word[FUNCCODE_LSB +: FUNCCODE_W];
    assign rs           = word[RS_LSB +: REG_W];
    assign rt           = word[RT_LSB +: REG_W];
    assign imm          = sign_ext_imm(word[IMM_LSB +: IMM_W]);
    assign unused_bit_s = word[16];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads, holds the returned instruction
// until the decode stage consumes it, and handles redirects and wrap-around.
module instr_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_en,
    output logic [31:0]           imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [FUNCCODE_W-1:0] funccode,
    output logic [REG_W-1:0]      rs,
    output logic [REG_W-1:0]      rt,
    output logic [31:0]           imm,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4
);

    fetch_state_e state_r;
    logic [31:0]  fetch_pc_r;
    logic [31:0]  instr_r;
    logic [31:0]  pc_r;
    logic         instr_valid_r;
    logic         imem_en_r;
    logic [31:0]  imem_addr_r;

    logic [31:0]  seq_pc_s;
    logic [31:0]  redirect_addr_s;
    logic         hold_fetch_s;

    assign seq_pc_s        = fetch_pc_r + PC_STEP;
    assign redirect_addr_s = word_align(redirect_pc);

    // Consuming the held word issues the next sequential read in the same
    // cycle, which is what sustains one instruction every two cycles.
    assign hold_fetch_s = (state_r == ST_HOLD) && !stall && !redirect && !rst;

    assign imem_en   = imem_en_r | hold_fetch_s;
    assign imem_addr = hold_fetch_s ? seq_pc_s : imem_addr_r;

    // Fetch FSM with its registered datapath and memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= word_align(RESET_PC);
            instr_r       <= 32'h0000_0000;
            pc_r          <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            imem_en_r     <= 1'b0;
            imem_addr_r   <= 32'h0000_0000;
        end else if (redirect) begin
            state_r       <= ST_REQ;
            fetch_pc_r    <= redirect_addr_s;
            instr_valid_r <= 1'b0;
            imem_en_r     <= 1'b1;
            imem_addr_r   <= redirect_addr_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_REQ;
                    imem_en_r   <= 1'b1;
                    imem_addr_r <= fetch_pc_r;
                end
                ST_REQ: begin
                    state_r   <= ST_WAIT;
                    imem_en_r <= 1'b0;
                end
                ST_WAIT: begin
                    state_r       <= ST_HOLD;
                    instr_r       <= imem_rdata;
                    pc_r          <= fetch_pc_r;
                    instr_valid_r <= 1'b1;
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_r       <= ST_WAIT;
                        fetch_pc_r    <= seq_pc_s;
                        imem_addr_r   <= seq_pc_s;
                        instr_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    instr_valid_r <= 1'b0;
                    imem_en_r     <= 1'b0;
                end
            endcase
        end
    end

    assign instr       = instr_r;
    assign pc          = pc_r;
    assign instr_valid = instr_valid_r;
    assign pc_plus4    = pc_r + PC_STEP;

    instr_field_split u_split (
        .word     (instr_r),
        .opcode   (opcode),
        .funccode (funccode),
        .rs       (rs),
        .rt       (rt),
        .imm      (imm)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic        instr_valid;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic [4:0]  funccode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int n_vec  = 0;
    int n_miss = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .funccode    (funccode),
        .rs          (rs),
        .rt          (rt),
        .imm         (imm),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000)      return 32'h0800_0001;
        else if (a == 32'h0000_0200) return 32'h1234_8000;
        else                         return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Synchronous instruction memory; junk when not enabled so stale data shows.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage should hold after each edge.
    bit          m_started = 1'b0;
    bit          m_idle, m_req, m_wait, m_valid;
    logic [31:0] m_next, m_pc, m_instr;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1;
            m_idle = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_valid = 1'b0;
            m_next = 32'h0000_0000; m_pc = 32'h0000_0000; m_instr = 32'h0000_0000;
        end else if (m_started) begin
            if (redirect) begin
                m_idle = 1'b0; m_req = 1'b1; m_wait = 1'b0; m_valid = 1'b0;
                m_next = redirect_pc & 32'hFFFF_FFFC;
            end else if (m_idle) begin
                m_idle = 1'b0; m_req = 1'b1;
            end else if (m_req) begin
                m_req = 1'b0; m_wait = 1'b1;
            end else if (m_wait) begin
                m_wait = 1'b0; m_valid = 1'b1;
                m_pc = m_next; m_instr = mem_word(m_next);
            end else if (m_valid && !stall) begin
                m_valid = 1'b0; m_wait = 1'b1;
                m_next = m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started && !rst) begin
            logic        exp_en;
            logic [31:0] exp_addr;
            exp_en   = m_req || (m_valid && !stall && !redirect);
            exp_addr = m_req ? m_next : m_pc + 32'd4;
            chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            chk("m_instr", instr, m_instr);
            chk("m_pc", pc, m_pc);
            chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("m_opcode", {27'd0, opcode}, {27'd0, m_instr[31:27]});
            chk("m_funccode", {27'd0, funccode}, {27'd0, m_instr[4:0]});
            chk("m_rs", {27'd0, rs}, {27'd0, m_instr[26:22]});
            chk("m_rt", {27'd0, rt}, {27'd0, m_instr[21:17]});
            chk("m_imm", imm, {{16{m_instr[15]}}, m_instr[15:0]});
            chk("m_imem_en", {31'd0, imem_en}, {31'd0, exp_en});
            if (exp_en) chk("m_imem_addr", imem_addr, exp_addr);
            chk("m_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick(); tick();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_en", {31'd0, imem_en}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        rst = 1'b0;

        // First fetch after release.
        tick();
        chk("first_en", {31'd0, imem_en}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        tick(); tick();
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_opcode", {27'd0, opcode}, 32'd1);
        chk("first_func", {27'd0, funccode}, 32'd1);
        chk("first_pc", pc, 32'h0);
        chk("first_pc4", pc_plus4, 32'h4);

        // Five stalled cycles in HOLD.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_en", {31'd0, imem_en}, 32'd0);
            chk("stall_instr", instr, 32'h0800_0001);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        #1;
        chk("release_en", {31'd0, imem_en}, 32'd1);
        chk("release_addr", imem_addr, 32'h4);
        tick();
        chk("release_valid_low", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("second_pc", pc, 32'h4);
        tick(); tick(); tick();

        // Redirect during WAIT.
        chk("pre_redir_valid", {31'd0, instr_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("redir_en", {31'd0, imem_en}, 32'd1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("redir_wait_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("redir_pc", pc, 32'h0000_0100);

        // Redirect and stall together in HOLD.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("prio_en", {31'd0, imem_en}, 32'd1);
        chk("prio_addr", imem_addr, 32'h0000_0200);
        tick(); tick();
        chk("prio_pc", pc, 32'h0000_0200);
        chk("neg_imm", imm, 32'hFFFF_8000);

        // Wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick(); tick();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        stall = 1'b0;
        #1;
        chk("wrap_addr", imem_addr, 32'h0);
        tick(); tick();
        chk("wrap_instr", instr, 32'h0800_0001);

        // One-cycle reset during WAIT.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstw_en", {31'd0, imem_en}, 32'd0);
        tick();
        chk("rstw_addr", imem_addr, 32'h0);
        chk("rstw_req_en", {31'd0, imem_en}, 32'd1);
        tick(); tick();
        chk("rstw_pc", pc, 32'h0);

        // Mixed traffic under model checking.
        for (int i = 0; i < 80; i++) begin
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_en  output  1  instruction-memory read enable.
REQ-005 imem_addr  output  32  byte address of the read; bits [1:0] always 0.
REQ-006 imem_rdata  input  32  read data, valid in the cycle after the edge that samples imem_en=1.
REQ-007 stall  input  1  control/decode stage not ready; the held instruction is not consumed.
REQ-008 redirect  input  1  a taken branch or jump; the fetch stream is replaced.
REQ-009 redirect_pc  input  32  new fetch address, qualified by redirect.
REQ-010 instr_valid  output  1  instr and its decoded fields are valid.
REQ-011 instr  output  32  held instruction word.
REQ-012 opcode  output  5  instr[31:27]; feeds control-unit opcode.
REQ-013 funccode  output  5  instr[4:0]; feeds control-unit funccode.
REQ-014 rs, rt  output  5 each  instr[26:22], instr[21:17].
REQ-015 imm  output  32  instr[15:0] sign-extended.
REQ-016 pc, pc_plus4  output  32 each  address of the held instruction and that address +4 (used as the brLink value).

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and HOLD, encoded as a 2-bit register.
REQ-018 IDLE SHALL go to REQ unconditionally.
REQ-019 REQ SHALL drive imem_en=1 and imem_addr=fetch_pc, then go to WAIT.
REQ-020 WAIT SHALL load imem_rdata into the instruction register, set pc=fetch_pc, set instr_valid=1, then go to HOLD.
REQ-021 HOLD with stall=1 SHALL keep every output unchanged.
REQ-022 HOLD with stall=0 SHALL:
- consume the instruction;
- set fetch_pc=fetch_pc+4 and drive imem_en=1, imem_addr=fetch_pc+4 in that same cycle;
- go to WAIT with instr_valid low on the next cycle.
REQ-023 Throughput SHALL be one instruction per 2 cycles without stalls; latency from the first REQ cycle to instr_valid SHALL be 2 edges.
REQ-024 imem_en SHALL be 0 in IDLE, WAIT and stalled HOLD.
REQ-025 redirect=1 in any non-reset state SHALL:
- set fetch_pc={redirect_pc[31:2],2'b00};
- clear instr_valid;
- discard any read in flight;
- go to REQ.
REQ-026 When redirect and stall are both high, redirect SHALL take priority.
REQ-027 The PC SHALL wrap modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000, and pc_plus4 wraps the same way.
REQ-028 opcode, funccode, rs, rt, imm and pc_plus4 SHALL be combinational functions of the registered instr and pc, so they change only with them.

Reset
REQ-029 While rst=1 at an edge:
- state=IDLE, fetch_pc=RESET_PC;
- instr=0, pc=0, instr_valid=0, imem_en=0, imem_addr=0.
REQ-030 Reset SHALL override redirect and stall.
REQ-031 Reset asserted mid-fetch SHALL discard the in-flight read; the first fetch after release SHALL be from RESET_PC.

Structure
REQ-032 The shared package kgp_risc_pkg SHALL hold:
- instruction field bit positions and widths;
- RESET_PC default;
- the FSM state encoding;
- the opcode/funccode widths common with the control unit.
REQ-033 One combinational sub-module, instr_field_split, SHALL extract opcode, funccode, rs, rt and sign-extended imm from a 32-bit word.
REQ-034 No other hierarchy.

Verification
REQ-035 Reset release, memory returning 32'h0800_0001 at address 0:
- imem_en high at addr 0 one edge after release;
- instr_valid after 2 more edges;
- opcode=5'b00001, funccode=5'b00001, pc=0, pc_plus4=4.
REQ-036 stall held 5 cycles in HOLD, then released:
- outputs stable throughout the stall;
- next fetch at addr 4;
- imem_en not asserted during the stall.
REQ-037 redirect=1 with redirect_pc=32'h0000_0103 during WAIT:
- the in-flight word is dropped;
- next imem_addr=32'h0000_0100;
- instr_valid low until that word arrives.
REQ-038 fetch_pc=32'hFFFF_FFFC, stall=0: pc_plus4=0 and the next imem_addr=0.
REQ-039 redirect and stall both high in HOLD: redirect wins, and the next cycle is REQ at redirect_pc.
REQ-040 rst pulsed for 1 cycle during WAIT:
- instr_valid=0 and imem_en=0 next cycle;
- the fetch restarts at RESET_PC;
- imm for instr[15:0]=16'h8000 is 32'hFFFF_8000.
